// File: rtl/tft_spi_driver_pkg.sv
// Shared TFT definitions: panel command opcodes, FSM state types and the
// power-up command ROM used by the SPI driver.
package tft_pkg;

  localparam logic [7:0] TFT_SWRESET = 8'h01;
  localparam logic [7:0] TFT_SLPOUT  = 8'h11;
  localparam logic [7:0] TFT_COLMOD  = 8'h3A;
  localparam logic [7:0] TFT_MADCTL  = 8'h36;
  localparam logic [7:0] TFT_DISPON  = 8'h29;
  localparam logic [7:0] TFT_CASET   = 8'h2A;
  localparam logic [7:0] TFT_RASET   = 8'h2B;
  localparam logic [7:0] TFT_RAMWR   = 8'h2C;

  localparam logic [7:0] COLMOD_18BIT = 8'h66;

  typedef enum logic [2:0] {
    S_HWRST,
    S_HWWAIT,
    S_SEND,
    S_DELAY,
    S_IDLE
  } init_state_e;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_SHIFT,
    SH_HOLD,
    SH_GAP
  } shift_state_e;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
    logic       delay;
  } init_entry_t;

  localparam logic [2:0] ROM_LAST = 3'd6;

  // Power-up sequence; delay marks the entries followed by the long settle wait.
  function automatic init_entry_t init_rom(input logic [2:0] idx, input logic [7:0] madctl);
    case (idx)
      3'd0:    return '{dc: 1'b0, data: TFT_SWRESET,  delay: 1'b1};
      3'd1:    return '{dc: 1'b0, data: TFT_SLPOUT,   delay: 1'b1};
      3'd2:    return '{dc: 1'b0, data: TFT_COLMOD,   delay: 1'b0};
      3'd3:    return '{dc: 1'b1, data: COLMOD_18BIT, delay: 1'b0};
      3'd4:    return '{dc: 1'b0, data: TFT_MADCTL,   delay: 1'b0};
      3'd5:    return '{dc: 1'b1, data: madctl,       delay: 1'b0};
      default: return '{dc: 1'b0, data: TFT_DISPON,   delay: 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/tft_spi_driver_if.sv
// Byte request handshake between the drawing stages (master) and the
// TFT SPI driver (slave).
interface tft_spi_driver_if;
    logic       transmit;
    logic       dc;
    logic [7:0] data;
    logic       busy;
    logic       init_done;

    modport master (output transmit, output dc, output data, input busy, input init_done);
    modport slave  (input transmit, input dc, input data, output busy, output init_done);
endinterface

// File: rtl/tft_spi_shifter.sv
// SPI mode-0 byte shifter: one load per byte, MSB first, CS framed, with a
// one-cycle CS-high gap before busy drops.
module tft_spi_shifter
    import tft_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       load_dc,
    input  logic [7:0] load_data,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       spi_dc
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    shift_state_e     state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    // NOTE: clocked state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= SH_IDLE;
            busy     <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_dc   <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
        end else begin
            case (state)
                SH_IDLE: begin
                    if (load) begin
                        state    <= SH_SHIFT;
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        spi_dc   <= load_dc;
                        spi_mosi <= load_data[7];
                        shreg    <= {load_data[6:0], 1'b0};
                        bit_cnt  <= 3'd7;
                        div_cnt  <= '0;
                        spi_sck  <= 1'b0;
                    end
                end
                SH_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        spi_sck <= ~spi_sck;
                        // MOSI advances on the falling edge so the panel samples stable data on the rise.
                        if (spi_sck) begin
                            if (bit_cnt == 3'd0) begin
                                state <= SH_HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt - 3'd1;
                                spi_mosi <= shreg[7];
                                shreg    <= {shreg[6:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SH_HOLD: begin
                    spi_cs_n <= 1'b1;
                    spi_mosi <= 1'b0;
                    state    <= SH_GAP;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= SH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/tft_spi_driver.sv
// TFT SPI driver: runs the panel power-up sequence after reset, then forwards
// byte requests from the drawing stages to the SPI shifter.
module tft_spi_driver
    import tft_pkg::*;
#(
    parameter int          CLK_DIV      = 2,
    parameter int          RST_CYCLES   = 500000,
    parameter int          DELAY_CYCLES = 6000000,
    parameter logic [7:0]  MADCTL_VAL   = 8'h48
) (
    input  logic              clk,
    input  logic              rst,
    tft_spi_driver_if.slave   host,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    output logic              spi_dc,
    output logic              tft_rst_n
);

    localparam int CNT_MAX = (RST_CYCLES > DELAY_CYCLES) ? RST_CYCLES : DELAY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    init_state_e  state;
    logic [CNT_W-1:0] delay_cnt;
    logic [2:0]   rom_idx;
    logic         sent;
    logic         init_done_q;
    init_entry_t  entry;

    logic         sh_load;
    logic         sh_dc;
    logic [7:0]   sh_data;
    logic         sh_busy;

    // NOTE: the ROM is a constant function of the index, so there is no storage to reset.
    assign entry = init_rom(rom_idx, MADCTL_VAL);

    // NOTE: every output gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        sh_load = 1'b0;
        sh_dc   = entry.dc;
        sh_data = entry.data;
        if (state == S_IDLE) begin
            sh_load = host.transmit && !sh_busy;
            sh_dc   = host.dc;
            sh_data = host.data;
        end else if (state == S_SEND && !sent) begin
            sh_load = !sh_busy;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_HWRST;
            tft_rst_n   <= 1'b0;
            init_done_q <= 1'b0;
            delay_cnt   <= CNT_W'(RST_CYCLES);
            rom_idx     <= 3'd0;
            sent        <= 1'b0;
        end else begin
            case (state)
                S_HWRST: begin
                    if (delay_cnt == '0) begin
                        tft_rst_n <= 1'b1;
                        delay_cnt <= CNT_W'(RST_CYCLES - 1);
                        state     <= S_HWWAIT;
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end
                S_HWWAIT: begin
                    if (delay_cnt == '0) state <= S_SEND;
                    else                 delay_cnt <= delay_cnt - 1'b1;
                end
                S_SEND: begin
                    // sent marks the byte as handed over; completion is the shifter going idle again.
                    if (!sent) begin
                        if (!sh_busy) sent <= 1'b1;
                    end else if (!sh_busy) begin
                        sent <= 1'b0;
                        if (rom_idx == ROM_LAST) begin
                            init_done_q <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            rom_idx <= rom_idx + 3'd1;
                            if (entry.delay) begin
                                delay_cnt <= CNT_W'(DELAY_CYCLES - 1);
                                state     <= S_DELAY;
                            end
                        end
                    end
                end
                S_DELAY: begin
                    if (delay_cnt == '0) state <= S_SEND;
                    else                 delay_cnt <= delay_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign host.busy      = !init_done_q || sh_busy;
    assign host.init_done = init_done_q;

    tft_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_dc   (sh_dc),
        .load_data (sh_data),
        .busy      (sh_busy),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_dc    (spi_dc)
    );

endmodule

// File: tb/tb_tft_spi_driver.sv
// Scoreboard bench for tft_spi_driver: a CLK_DIV=2 instance (a) and a
// CLK_DIV=1 instance (b), with an SPI bus decoder per instance.
module tb_tft_spi_driver;

    localparam int R = 20;
    localparam int D = 30;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic sck_a, mosi_a, cs_a, dc_a, trst_a;
    logic sck_b, mosi_b, cs_b, dc_b, trst_b;

    tft_spi_driver_if if_a ();
    tft_spi_driver_if if_b ();

    tft_spi_driver #(.CLK_DIV(2), .RST_CYCLES(R), .DELAY_CYCLES(D), .MADCTL_VAL(8'h48)) dut_a (
        .clk(clk), .rst(rst_a), .host(if_a), .spi_sck(sck_a), .spi_mosi(mosi_a),
        .spi_cs_n(cs_a), .spi_dc(dc_a), .tft_rst_n(trst_a));

    tft_spi_driver #(.CLK_DIV(1), .RST_CYCLES(R), .DELAY_CYCLES(D), .MADCTL_VAL(8'h48)) dut_b (
        .clk(clk), .rst(rst_b), .host(if_b), .spi_sck(sck_b), .spi_mosi(mosi_b),
        .spi_cs_n(cs_b), .spi_dc(dc_b), .tft_rst_n(trst_b));

    always #5 clk = ~clk;

    typedef struct { logic dc; logic [7:0] data; } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_init_err = 0;
    int nbits[2];
    logic [7:0] sh[2];
    logic dc0[2];
    logic prev_sck[2];
    logic prev_cs[2];
    int last_rise[2];
    int cs_falls[2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input int id, input logic d_c, input logic [7:0] d);
        exp_t e;
        e.dc = d_c;
        e.data = d;
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
    endtask

    task automatic push_init(input int id);
        push(id, 0, 8'h01); push(id, 0, 8'h11); push(id, 0, 8'h3A); push(id, 1, 8'h66);
        push(id, 0, 8'h36); push(id, 1, 8'h48); push(id, 0, 8'h29);
    endtask

    // Decodes one SPI bus: shifts MOSI on SCK rises inside a CS frame and checks each full byte.
    task automatic sample(input int id, input logic rst_l, input logic sck, input logic cs_n,
                          input logic mosi, input logic dc);
        exp_t e;
        logic have;
        if (!rst_l) begin
            nbits[id] = 0; prev_sck[id] = 1'b0; prev_cs[id] = 1'b1;
            return;
        end
        if (prev_cs[id] && !cs_n) cs_falls[id]++;
        if (cs_n) begin
            nbits[id] = 0;
        end else if (sck && !prev_sck[id]) begin
            if (id == 1 && nbits[id] > 0) check("sck_period_b", cyc - last_rise[id], 2);
            last_rise[id] = cyc;
            if (nbits[id] == 0) dc0[id] = dc;
            sh[id] = {sh[id][6:0], mosi};
            nbits[id]++;
            if (nbits[id] == 8) begin
                nbits[id] = 0;
                have = (id == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
                check(id == 0 ? "byte_expected_a" : "byte_expected_b", have, 1);
                if (have) begin
                    if (id == 0) e = q_a.pop_front();
                    else         e = q_b.pop_front();
                    check(id == 0 ? "byte_a" : "byte_b", {dc0[id], dc, sh[id]}, {e.dc, e.dc, e.data});
                end
            end
        end
        prev_sck[id] = sck;
        prev_cs[id]  = cs_n;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        sample(0, rst_a, sck_a, cs_a, mosi_a, dc_a);
        sample(1, rst_b, sck_b, cs_b, mosi_b, dc_b);
        if (rst_a && !if_a.init_done && !if_a.busy) busy_init_err++;
    end

    function automatic logic busy_of(input int id);
        return (id == 0) ? if_a.busy : if_b.busy;
    endfunction

    function automatic logic done_of(input int id);
        return (id == 0) ? if_a.init_done : if_b.init_done;
    endfunction

    task automatic drive(input int id, input logic t, input logic d_c, input logic [7:0] d);
        if (id == 0) begin if_a.transmit = t; if_a.dc = d_c; if_a.data = d; end
        else         begin if_b.transmit = t; if_b.dc = d_c; if_b.data = d; end
    endtask

    // Upstream-style request: wait for busy low, pulse transmit for one cycle.
    task automatic send(input int id, input logic d_c, input logic [7:0] d, input bit expect_it);
        int n = 0;
        while (busy_of(id) && n < 2000) begin @(negedge clk); n++; end
        check("free_before_send", busy_of(id), 0);
        drive(id, 1, d_c, d);
        if (expect_it) push(id, d_c, d);
        @(negedge clk);
        drive(id, 0, d_c, d);
    endtask

    task automatic wait_init(input int id);
        int n = 0;
        while (!done_of(id) && n < 5000) begin @(negedge clk); n++; end
        check("init_done", done_of(id), 1);
        check("idle_after_init", busy_of(id), 0);
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        while (busy_of(id) && n < 2000) begin @(negedge clk); n++; end
        check("idle_wait", busy_of(id), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic       dc_tab[5]  = '{0, 1, 1, 1, 1};
    logic [7:0] dat_tab[5] = '{8'h2A, 8'h00, 8'h05, 8'h00, 8'h1A};

    initial begin
        int lo, hi, hc, f0;
        rst_a = 0; rst_b = 0;
        drive(0, 0, 0, 8'h00);
        drive(1, 0, 0, 8'h00);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", if_a.busy, 1);
        check("rst_init_done", if_a.init_done, 0);
        check("rst_sck", sck_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_cs_n", cs_a, 1);
        check("rst_dc", dc_a, 0);
        check("rst_tft_rst_n", trst_a, 0);
        check("rst_busy_b", if_b.busy, 1);

        // Power-up sequence
        push_init(0);
        push_init(1);
        rst_a = 1; rst_b = 1;
        @(negedge clk);
        lo = 0;
        while (!trst_a && lo < 4 * R) begin lo++; @(negedge clk); end
        check("tft_rst_low_cycles", lo, R);
        hi = 0;
        while (cs_a && hi < 4 * R) begin hi++; @(negedge clk); end
        check("tft_rst_high_window", (hi >= R) && (hi <= R + 2), 1);
        wait_init(0);
        wait_init(1);
        check("init_bytes_a_all_seen", q_a.size(), 0);
        check("init_bytes_b_all_seen", q_b.size(), 0);
        check("busy_high_during_init", busy_init_err, 0);

        // Single byte A5 with a request pulsed mid-byte that must be dropped
        repeat (3) @(negedge clk);
        f0 = cs_falls[0];
        send(0, 1, 8'hA5, 1);
        check("busy_rise_next_cycle", if_a.busy, 1);
        hc = 0;
        while (if_a.busy && hc < 200) begin
            hc++;
            if (hc == 5) drive(0, 1, 1, 8'hFF);
            if (hc == 6) drive(0, 0, 1, 8'hFF);
            @(negedge clk);
        end
        check("busy_high_cycles_div2", hc, 34);
        repeat (4) @(negedge clk);
        check("busy_ignored_request", cs_falls[0] - f0, 1);
        check("a5_consumed", q_a.size(), 0);

        // Back-to-back CASET-style burst
        f0 = cs_falls[0];
        for (int i = 0; i < 5; i++) send(0, dc_tab[i], dat_tab[i], 1);
        wait_idle(0);
        repeat (2) @(negedge clk);
        check("burst_frames", cs_falls[0] - f0, 5);
        check("burst_consumed", q_a.size(), 0);

        // Reset in the middle of bit 3
        send(0, 0, 8'h3C, 0);
        repeat (17) @(negedge clk);
        check("mid_byte_cs_low", cs_a, 0);
        check("mid_byte_bit3_mosi", mosi_a, 1);
        rst_a = 0;
        @(negedge clk);
        check("abort_cs_n", cs_a, 1);
        check("abort_sck", sck_a, 0);
        check("abort_busy", if_a.busy, 1);
        check("abort_tft_rst_n", trst_a, 0);
        check("abort_init_done", if_a.init_done, 0);
        push_init(0);
        rst_a = 1;
        wait_init(0);
        check("reinit_bytes_seen", q_a.size(), 0);
        check("busy_high_during_reinit", busy_init_err, 0);

        // CLK_DIV=1 single byte 80
        send(1, 1, 8'h80, 1);
        hc = 0;
        while (if_b.busy && hc < 200) begin hc++; @(negedge clk); end
        check("busy_high_cycles_div1", hc, 18);
        repeat (2) @(negedge clk);
        check("div1_byte_consumed", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
